disp_src_ctrl: RTL

Display-source controller for the alarm clock. Drives the select line of the 4-bit 2:1 digit muxes that choose between current-time digits (sel=0) and alarm-time digits (sel=1). Sequences the view, alarm-edit and auto-return modes from debounced single-cycle button pulses. Provides field-blink blanking and increment strobes to the alarm registers.

---
 rtl/disp_pkg.sv | 19 +
 rtl/idle_timer.sv | 32 +++
 rtl/disp_src_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the alarm-clock display-source controller:
// state encoding, default timeout and a small state helper.
package disp_pkg;

    typedef enum logic [1:0] {
        SHOW_TIME  = 2'd0,
        SHOW_ALARM = 2'd1,
        EDIT_HR    = 2'd2,
        EDIT_MIN   = 2'd3
    } disp_state_e;

    localparam int DISP_TIMEOUT_S = 5;
    localparam int DISP_CNT_W     = 4;

    function automatic logic is_edit(input disp_state_e s);
        return (s == EDIT_HR) || (s == EDIT_MIN);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-seconds counter: clear wins over counting, saturates at TIMEOUT_S-1,
// and flags expiry combinationally on the tick that would reach TIMEOUT_S.
module idle_timer
    import disp_pkg::*;
#(
    parameter int TIMEOUT_S = DISP_TIMEOUT_S,
    parameter int CNT_W     = DISP_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_S - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && tick && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expire = en && tick && (cnt == LAST);

endmodule

// File: rtl/disp_src_ctrl.sv
// Display-source controller: time/alarm view select, alarm edit sequencing,
// auto-return on idle. Field blinking is built only with DISP_BLINK_EN.
module disp_src_ctrl
    import disp_pkg::*;
#(
    parameter int TIMEOUT_S = DISP_TIMEOUT_S,
    parameter int CNT_W     = DISP_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic btn_view,
    input  logic btn_set,
    input  logic btn_up,
    input  logic alarm_ring,
    output logic sel,
    output logic blank_hr,
    output logic blank_min,
    output logic inc_hr,
    output logic inc_min
);

    disp_state_e state, state_d;
    logic        any_btn;
    logic        expire;
    logic        tmr_clr;
    logic        inc_hr_d, inc_min_d;

    assign any_btn = btn_view | btn_set | btn_up;

    always_comb begin
        state_d   = state;
        inc_hr_d  = 1'b0;
        inc_min_d = 1'b0;
        if (alarm_ring) begin
            state_d = SHOW_TIME;
        end else begin
            // btn_up acts on the field being left, so it uses the current state
            inc_hr_d  = btn_up && (state == EDIT_HR);
            inc_min_d = btn_up && (state == EDIT_MIN);
            if (btn_set) begin
                unique case (state)
                    SHOW_TIME, SHOW_ALARM: state_d = EDIT_HR;
                    EDIT_HR:               state_d = EDIT_MIN;
                    EDIT_MIN:              state_d = SHOW_ALARM;
                    default:               state_d = SHOW_TIME;
                endcase
            end else if (btn_view) begin
                if (state == SHOW_TIME)
                    state_d = SHOW_ALARM;
                else if (state == SHOW_ALARM)
                    state_d = SHOW_TIME;
            end else if (expire && !any_btn) begin
                state_d = SHOW_TIME;
            end
        end
    end

    assign tmr_clr = (state_d != state) || any_btn;

    idle_timer #(
        .TIMEOUT_S (TIMEOUT_S),
        .CNT_W     (CNT_W)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (state != SHOW_TIME),
        .tick   (tick_1hz),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SHOW_TIME;
            sel     <= 1'b0;
            inc_hr  <= 1'b0;
            inc_min <= 1'b0;
        end else begin
            state   <= state_d;
            sel     <= (state_d != SHOW_TIME);
            inc_hr  <= inc_hr_d;
            inc_min <= inc_min_d;
        end
    end

`ifdef DISP_BLINK_EN
    logic phase, phase_d;

    // Entering an edit field restarts the blink with the digits visible.
    always_comb begin
        phase_d = phase;
        if (is_edit(state_d) && (state_d != state))
            phase_d = 1'b0;
        else if (tick_2hz)
            phase_d = ~phase;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= 1'b0;
            blank_hr  <= 1'b0;
            blank_min <= 1'b0;
        end else begin
            phase     <= phase_d;
            blank_hr  <= phase_d && (state_d == EDIT_HR);
            blank_min <= phase_d && (state_d == EDIT_MIN);
        end
    end
`else
    logic unused_tick_2hz;
    assign unused_tick_2hz = tick_2hz;
    assign blank_hr        = 1'b0;
    assign blank_min       = 1'b0;
`endif

endmodule
